// File: rtl/slc3_input_pkg.sv
// Shared definitions for the SLC-3 push-button input path.
//   btn_state_t : per-channel debounce state machine encoding
//   cnt_width() : bit width needed to hold the values 0..max_val
package slc3_input_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Never narrower than one bit, so parameters of 0 still give a legal vector.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: synchroniser, polarity normalisation, debounce
// state machine and optional auto-repeat.
//   Clk           : sole clock, rising edge
//   Reset         : asynchronous, active-low
//   btn_raw       : raw asynchronous pin
//   pressed       : debounced level, 1 while held
//   press_pulse   : one-cycle strobe on accepted press and on each auto-repeat
//   release_pulse : one-cycle strobe on accepted release
//
// state        | meaning
// -------------+------------------------------------------------------
// IDLE         | released and stable
// PRESS_WAIT   | act seen high, counting stable samples before accepting
// HELD         | press accepted
// RELEASE_WAIT | act seen low while held, counting before accepting
module button_channel
  import slc3_input_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_raw,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int DW  = cnt_width(DEBOUNCE_CYCLES);
  localparam int RPW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

  localparam logic          REL_LVL    = (ACTIVE_LOW != 0);
  localparam logic [DW-1:0] DB_MAX     = DW'(DEBOUNCE_CYCLES);
  localparam logic [RPW-1:0] RPT_FIRST  = RPW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RPW-1:0] RPT_RELOAD = RPW'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   act;

  btn_state_t     state_q, state_d;
  logic [DW-1:0]  cnt_q, cnt_d;
  logic [RPW-1:0] rpt_q, rpt_d;
  logic           press_d, release_d;

  // Synchroniser resets to the released pin level so reset exit is quiet.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_q <= {SYNC_STAGES{REL_LVL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign act = sync_q[SYNC_STAGES-1] ^ REL_LVL;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rpt_d     = rpt_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (act) begin
          state_d = PRESS_WAIT;
          cnt_d   = DW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!act) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_MAX) begin
          state_d = HELD;
          press_d = 1'b1;
          rpt_d   = RPT_FIRST;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      HELD: begin
        if (!act) begin
          state_d = RELEASE_WAIT;
          cnt_d   = DW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (act) begin
          state_d = HELD;
        end else if (cnt_q == DB_MAX) begin
          state_d   = IDLE;
          cnt_d     = '0;
          rpt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Repeat down-counter keeps running through RELEASE_WAIT bounces; an
    // accepted release on the same edge wins over a due repeat.
    if ((REPEAT_DELAY > 0) && !release_d &&
        ((state_q == HELD) || (state_q == RELEASE_WAIT))) begin
      if (rpt_q == '0) begin
        press_d = 1'b1;
        rpt_d   = RPT_RELOAD;
      end else begin
        rpt_d = rpt_q - RPW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rpt_q         <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rpt_q         <= rpt_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end

  assign pressed = (state_q == HELD) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: CHANNELS independent copies of button_channel.
//   Clk           : sole clock, rising edge
//   Reset         : asynchronous, active-low
//   btn_raw       : raw asynchronous button pins
//   pressed       : debounced levels, active-high
//   press_pulse   : one-cycle press / auto-repeat strobes
//   release_pulse : one-cycle release strobes
module button_conditioner
  import slc3_input_pkg::*;
#(
  parameter int CHANNELS        = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse
);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    button_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_channel (
      .Clk           (Clk),
      .Reset         (Reset),
      .btn_raw       (btn_raw[ch]),
      .pressed       (pressed[ch]),
      .press_pulse   (press_pulse[ch]),
      .release_pulse (release_pulse[ch])
    );
  end

endmodule
